id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register and operand-forwarding stage of the 5-stage pipelined CPU. It captures the decoded instruction from ID on each clock, holds or bubbles it under stall/flush, and drives the ALU's `src1`, `src2` and 4-bit `ctrl` inputs. Operands come through an EX/MEM > MEM/WB bypass network. It also flags load-use hazards to the ID-stage hazard logic.

## Interface
- `DATA_W`, 32, datapath width
- `REG_AW`, 5, register-index width
- `clk_i` in 1: clock, rising edge
- `rst_i` in 1: reset, synchronous, active-high
- `stall_i` in 1: hold current EX contents
- `flush_i` in 1: load a bubble
- `id_valid_i` in 1: ID holds a real instruction
- `id_rs_data_i`, `id_rt_data_i` in DATA_W: register-file read data
- `id_imm_i` in DATA_W: sign-extended immediate
- `id_rs_i`, `id_rt_i`, `id_rd_i` in REG_AW: source/dest indices
- `id_alu_ctrl_i` in 4: ALU op (package encoding)
- `id_alu_src_i` in 1: 1 = immediate as src2
- `id_reg_dst_i` in 1: 1 = dest is rd, 0 = rt
- `id_reg_write_i`, `id_mem_read_i`, `id_mem_write_i`, `id_mem_to_reg_i` in 1: control bits
- `exmem_reg_write_i` in 1, `exmem_rd_i` in REG_AW, `exmem_result_i` in DATA_W: EX/MEM bypass
- `memwb_reg_write_i` in 1, `memwb_rd_i` in REG_AW, `memwb_data_i` in DATA_W: MEM/WB bypass
- `alu_src1_o`, `alu_src2_o` out DATA_W: ALU operands
- `alu_ctrl_o` out 4: ALU op
- `ex_store_data_o` out DATA_W: forwarded rt value for stores
- `ex_dst_o` out REG_AW: resolved destination index
- `ex_valid_o`, `ex_reg_write_o`, `ex_mem_read_o`, `ex_mem_write_o`, `ex_mem_to_reg_o` out 1: registered control
- `load_use_o` out 1: ID instruction reads the register a load in EX writes

## Operation
- **Register update** at each rising edge, in priority order:
  - `rst_i` → all fields 0.
  - `flush_i` → bubble: all fields 0. Flush wins over stall.
  - `stall_i` → hold all fields.
  - Otherwise → capture the ID inputs.
- **Bubble** = valid 0, `reg_write`/`mem_read`/`mem_write`/`mem_to_reg` 0, `alu_ctrl` 4'b0000 (AND), indices 0, data 0.
- **Destination**: `ex_dst` = `id_reg_dst_i` ? `id_rd_i` : `id_rt_i`, resolved at capture.
- **Forwarding**: computed combinationally from registered `rs`/`rt` and the current bypass inputs, per operand:
  - EX/MEM if `exmem_reg_write_i` && `exmem_rd_i` != 0 && `exmem_rd_i` == index.
  - Else MEM/WB under the same condition.
  - Else the registered read data.
  - Index 0 is never forwarded.
- **Operand select**:
  - `alu_src1_o` = forwarded rs.
  - `ex_store_data_o` = forwarded rt.
  - `alu_src2_o` = `alu_src` ? registered imm : forwarded rt.
- **Held instruction**: while stalled, forwarding keeps tracking the current bypass inputs, so the held instruction sees the newest producer.
- **Load-use**: `load_use_o` = `ex_valid` && `ex_mem_read` && `ex_dst` != 0 && (`ex_dst` == `id_rs_i` || (`ex_dst` == `id_rt_i` && !`id_alu_src_i`)).
  - Combinational; upstream logic raises `flush_i` for one cycle from it.
- No arithmetic is performed here; all widths pass through unchanged.

## Timing
- 1-cycle latency from ID inputs to registered outputs.
- 0-cycle, combinational paths from bypass inputs to `alu_src*_o` and `ex_store_data_o`.
- Reset values: every output 0, except that `alu_src*_o` and `ex_store_data_o` are whatever the forwarding muxes select.
- Reset asserted mid-stall → contents cleared at the next edge; the stall is ignored.
- A bubble in EX never asserts `load_use_o` and never writes.

## Structure
- **Package `cpu_pkg`**:
  - `DATA_W`, `REG_AW`.
  - ALU op constants: AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110, SLT 4'b0111, MUL 4'b1110.
  - Forward-select enum: REG, EXMEM, MEMWB.
- **Sub-module `fwd_mux`**: index, reg data, both bypass ports → data out. Instantiated twice (rs, rt).

## Test plan
- **Reset**: `rst_i` high with random ID inputs → after the edge all control outputs 0 and `alu_ctrl_o` 4'b0000.
- **ADD capture**: rs_data 5, rt_data 7, alu_src 0, ctrl 4'b0010, reg_dst 1, rd 3 → next cycle `alu_src1_o`=5, `alu_src2_o`=7, `alu_ctrl_o`=4'b0010, `ex_dst_o`=3.
- **Forwarding priority**:
  - rs=4, EX/MEM writes r4=0x11, MEM/WB writes r4=0x22 → `alu_src1_o`=0x11.
  - Drop EX/MEM → 0x22.
  - Both write r0 with rs=0 → register value.
- **Stall, then flush**:
  - `stall_i` for 2 cycles with new ID inputs → outputs unchanged.
  - Assert `stall_i` and `flush_i` together → bubble.
- **Load-use**: EX holds lw to r8, ID reads rs=8 → `load_use_o`=1. Same with ID rt=8 and alu_src 1 → 0.
- **Stall with changing bypass**: stall while the EX/MEM value for rs changes 0xA→0xB → `alu_src1_o` follows to 0xB the same cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ALU op encodings and forwarding select for the pipelined CPU
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1110;
  typedef enum logic [1:0] {FWD_REG, FWD_EXMEM, FWD_MEMWB} fwd_sel_e;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks the newest value for one source register, EX/MEM over MEM/WB over the register file
module fwd_mux import cpu_pkg::*; #(
  parameter int DW = cpu_pkg::DATA_W,
  parameter int AW = cpu_pkg::REG_AW
) (
  input  logic [AW-1:0] idx,
  input  logic [DW-1:0] reg_data,
  input  logic          exmem_we,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_data,
  input  logic          memwb_we,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] data
);
  fwd_sel_e sel;
  always_comb begin
    sel = (exmem_we && exmem_rd != '0 && exmem_rd == idx) ? FWD_EXMEM :
          (memwb_we && memwb_rd != '0 && memwb_rd == idx) ? FWD_MEMWB : FWD_REG;
    data = (sel == FWD_EXMEM) ? exmem_data : (sel == FWD_MEMWB) ? memwb_data : reg_data;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use detection
module id_ex_stage #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [3:0]        id_alu_ctrl_i,
  input  logic              id_alu_src_i,
  input  logic              id_reg_dst_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              id_mem_to_reg_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [3:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] ex_store_data_o,
  output logic [REG_AW-1:0] ex_dst_o,
  output logic              ex_valid_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_mem_to_reg_o,
  output logic              load_use_o
);
  logic              alu_src;
  logic [REG_AW-1:0] rs, rt;
  logic [DATA_W-1:0] rs_data, rt_data, imm, fwd_rs, fwd_rt;
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      ex_valid_o      <= 1'b0;
      ex_reg_write_o  <= 1'b0;
      ex_mem_read_o   <= 1'b0;
      ex_mem_write_o  <= 1'b0;
      ex_mem_to_reg_o <= 1'b0;
      alu_ctrl_o      <= cpu_pkg::ALU_AND;
      alu_src         <= 1'b0;
      rs              <= '0;
      rt              <= '0;
      ex_dst_o        <= '0;
      rs_data         <= '0;
      rt_data         <= '0;
      imm             <= '0;
    end else if (!stall_i) begin
      ex_valid_o      <= id_valid_i;
      ex_reg_write_o  <= id_reg_write_i;
      ex_mem_read_o   <= id_mem_read_i;
      ex_mem_write_o  <= id_mem_write_i;
      ex_mem_to_reg_o <= id_mem_to_reg_i;
      alu_ctrl_o      <= id_alu_ctrl_i;
      alu_src         <= id_alu_src_i;
      rs              <= id_rs_i;
      rt              <= id_rt_i;
      ex_dst_o        <= id_reg_dst_i ? id_rd_i : id_rt_i;
      rs_data         <= id_rs_data_i;
      rt_data         <= id_rt_data_i;
      imm             <= id_imm_i;
    end
  end
  fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_fwd_rs (
    .idx(rs), .reg_data(rs_data),
    .exmem_we(exmem_reg_write_i), .exmem_rd(exmem_rd_i), .exmem_data(exmem_result_i),
    .memwb_we(memwb_reg_write_i), .memwb_rd(memwb_rd_i), .memwb_data(memwb_data_i),
    .data(fwd_rs)
  );
  fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_fwd_rt (
    .idx(rt), .reg_data(rt_data),
    .exmem_we(exmem_reg_write_i), .exmem_rd(exmem_rd_i), .exmem_data(exmem_result_i),
    .memwb_we(memwb_reg_write_i), .memwb_rd(memwb_rd_i), .memwb_data(memwb_data_i),
    .data(fwd_rt)
  );
  always_comb begin
    alu_src1_o      = fwd_rs;
    ex_store_data_o = fwd_rt;
    alu_src2_o      = alu_src ? imm : fwd_rt;
    load_use_o      = ex_valid_o && ex_mem_read_o && ex_dst_o != '0 &&
                      (ex_dst_o == id_rs_i || (ex_dst_o == id_rt_i && !id_alu_src_i));
  end
endmodule
